rd_sched_arb: RTL
=================

Name: rd_sched_arb

Overview:
- Round-robin packet scheduler sharing the single read/parity-check output stage among PORT_NUM port read channels.
- Each port raises a request when a packet is ready to read. The arbiter grants one port at a time and holds the grant for the whole packet (sop..eop).
- It muxes the granted port's sop/eop/vld/data into one registered stream that feeds the odd-parity stage, then rotates priority.

Parameters:
- PORT_NUM, 4, number of requesting read ports (2..8).
- DATA_W, 8, data width per port.
- ID_W, 2, width of grant index; equals clog2(PORT_NUM).
- TIMEOUT, 16, maximum cycles a grant waits for sop before it is revoked (≥2).

Ports:
- sys_clk  in  1  system clock; all logic is rising-edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- por_req  in  PORT_NUM  bit i high: port i has a packet ready; level, held until granted.
- por_gnt  out  PORT_NUM  one-hot grant, registered.
- por_rd_sop  in  PORT_NUM  per-port start of packet.
- por_rd_eop  in  PORT_NUM  per-port end of packet.
- por_rd_vld  in  PORT_NUM  per-port beat valid.
- por_rd_data  in  PORT_NUM*DATA_W  per-port data; port i occupies [i*DATA_W +: DATA_W].
- rd_sop  out  1  muxed sop, registered.
- rd_eop  out  1  muxed eop, registered.
- rd_vld  out  1  muxed valid, registered.
- rd_data  out  DATA_W  muxed data, registered.
- gnt_id  out  ID_W  index of the current or last granted port.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a grant is revoked for missing sop.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (sys_rst_n). Asserting it at any time, including mid-packet, immediately drives these outputs to 0: por_gnt, rd_sop, rd_eop, rd_vld, rd_data, gnt_id, busy, timeout_err.
  - Reset also sets state to IDLE, the timeout counter to 0, and the RR pointer last_id to PORT_NUM-1 (port 0 wins first).
- FSM states: IDLE, WAIT_SOP, XFER, GAP.
- IDLE:
  - If por_req != 0, choose the first set bit searching last_id+1, last_id+2, … modulo PORT_NUM.
  - Next cycle: por_gnt = one-hot(winner), gnt_id = winner, last_id = winner, state = WAIT_SOP.
  - Otherwise remain in IDLE.
- WAIT_SOP:
  - Only the granted port's inputs are observed.
  - Granted vld&sop&~eop → XFER.
  - Granted vld&sop&eop (single-beat packet) → GAP.
  - Granted vld without sop → beat is not forwarded (dropped).
  - Counter increments every cycle without sop. If the counter equals TIMEOUT-1 and there is no sop this cycle: next cycle timeout_err=1 for one cycle, por_gnt=0, state=GAP. The grant is therefore held exactly TIMEOUT cycles.
- XFER: forward every granted beat. Granted vld&eop → GAP. A second sop inside a packet is forwarded unchanged; it does not restart the packet.
- GAP: exactly one cycle; por_gnt=0; then IDLE. Minimum spacing between grants is therefore 2 idle cycles after an eop.
- por_gnt drops in the cycle after the eop beat is accepted (registered transition into GAP).
- Datapath:
  - rd_sop/rd_eop/rd_vld equal the granted port's inputs, gated by the forwarding rules above, with 1-cycle latency.
  - rd_sop/rd_eop/rd_vld are 0 when nothing is forwarded.
  - rd_data updates only on forwarded beats and otherwise holds.
- Non-granted ports' sop/eop/vld/data are ignored in all states and never reach the output.
- A request dropped before grant is simply not selected. Deasserting por_req after grant does not affect the ongoing packet.
- Latency: request seen at cycle T → grant at T+1; sop driven at T+2 → rd_sop at T+3.

Test Plan:
- Only por_req=4'b0100; port 2 sends a 4-beat packet A0..A3 → por_gnt=0100 one cycle after the request, gnt_id=2; rd_vld high 4 cycles with rd_data A0..A3; rd_sop on A0, rd_eop on A3; grant low the cycle after eop.
- por_req=4'b1111 held, each port sends 2-beat packets → grant order 0,1,2,3,0; two grant-free cycles between packets.
- Port 1 granted, sends a single beat with sop=eop=1, data 8'h5A → rd_sop=rd_eop=rd_vld=1, rd_data=5A for one cycle; FSM returns to IDLE via GAP.
- Port 3 granted, never asserts sop (TIMEOUT=16) → grant held 16 cycles; timeout_err pulses once; next request (port 0) granted afterward, with port 0 still next in RR order.
- During port 0's packet, port 2 drives vld/sop/data=FF → no output trace of FF; rd_data shows only port 0 beats.
- sys_rst_n pulled low mid-XFER between clock edges → all outputs 0 immediately; after release, por_req=0001 → port 0 granted (pointer reset).

Source files
------------

// File: rtl/rd_sched_arb.sv
// rd_sched_arb: round-robin scheduler that lends the single read/parity stage to one port per packet.
// Latency: request -> grant 1 cycle; granted beat -> rd_* 1 cycle; at least 2 grant-free cycles after eop.
// Backpressure: no stall on the output; ports hold por_req until granted, a grant with no sop is revoked after TIMEOUT cycles.
// Ports: sys_clk/sys_rst_n clock and async active-low reset; por_req/por_gnt per-port request and one-hot grant;
//        por_rd_sop/eop/vld/data per-port read streams; rd_sop/eop/vld/data registered muxed stream;
//        gnt_id current/last granted port; busy FSM not idle; timeout_err one-cycle pulse on sop timeout.
module rd_sched_arb #(
   parameter int PORT_NUM = 4,
   parameter int DATA_W   = 8,
   parameter int ID_W     = $clog2(PORT_NUM),
   parameter int TIMEOUT  = 16
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic [PORT_NUM-1:0]        por_req,
   output logic [PORT_NUM-1:0]        por_gnt,
   input  logic [PORT_NUM-1:0]        por_rd_sop,
   input  logic [PORT_NUM-1:0]        por_rd_eop,
   input  logic [PORT_NUM-1:0]        por_rd_vld,
   input  logic [PORT_NUM*DATA_W-1:0] por_rd_data,
   output logic                       rd_sop,
   output logic                       rd_eop,
   output logic                       rd_vld,
   output logic [DATA_W-1:0]          rd_data,
   output logic [ID_W-1:0]            gnt_id,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT_SOP, XFER, GAP} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     last_id, last_id_nxt;
   logic [ID_W-1:0]     gnt_id_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [PORT_NUM-1:0] por_gnt_nxt;
   logic                rd_sop_nxt, rd_eop_nxt, rd_vld_nxt, timeout_err_nxt;
   logic [DATA_W-1:0]   rd_data_nxt;

   // Round-robin pick: first requester after last_id, wrapping modulo PORT_NUM.
   logic [ID_W-1:0]     win_id;
   logic [ID_W-1:0]     rr_idx;
   logic                found;

   always_comb begin
      win_id = '0;
      found  = 1'b0;
      rr_idx = '0;
      for (int i = 1; i <= PORT_NUM; i++) begin
         rr_idx = ID_W'((int'(last_id) + i) % PORT_NUM);
         if (!found && por_req[rr_idx]) begin
            found  = 1'b1;
            win_id = rr_idx;
         end
      end
   end

   // Only the granted port's stream is looked at; everything else is ignored.
   logic [DATA_W-1:0] data_arr [PORT_NUM];
   logic              g_sop, g_eop, g_vld;
   logic [DATA_W-1:0] g_data;

   always_comb begin
      for (int i = 0; i < PORT_NUM; i++) begin
         data_arr[i] = por_rd_data[i*DATA_W +: DATA_W];
      end
   end

   assign g_sop  = por_rd_sop[gnt_id];
   assign g_eop  = por_rd_eop[gnt_id];
   assign g_vld  = por_rd_vld[gnt_id];
   assign g_data = data_arr[gnt_id];

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt       = state;
      last_id_nxt     = last_id;
      gnt_id_nxt      = gnt_id;
      cnt_nxt         = cnt;
      por_gnt_nxt     = por_gnt;
      rd_sop_nxt      = 1'b0;
      rd_eop_nxt      = 1'b0;
      rd_vld_nxt      = 1'b0;
      rd_data_nxt     = rd_data;
      timeout_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt   = WAIT_SOP;
               por_gnt_nxt = PORT_NUM'(1) << win_id;
               gnt_id_nxt  = win_id;
               last_id_nxt = win_id;
               cnt_nxt     = '0;
            end
         end
         WAIT_SOP: begin
            if (g_vld && g_sop) begin
               rd_vld_nxt  = 1'b1;
               rd_sop_nxt  = 1'b1;
               rd_eop_nxt  = g_eop;
               rd_data_nxt = g_data;
               if (g_eop) begin
                  // single-beat packet: straight to the gap cycle
                  state_nxt   = GAP;
                  por_gnt_nxt = '0;
               end else begin
                  state_nxt = XFER;
               end
            end else if (cnt == CNT_W'(TIMEOUT-1)) begin
               // grant has now been held TIMEOUT cycles with no sop
               timeout_err_nxt = 1'b1;
               por_gnt_nxt     = '0;
               state_nxt       = GAP;
            end else begin
               // beats without sop are dropped here, not forwarded
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         XFER: begin
            if (g_vld) begin
               // a repeated sop mid-packet passes through unchanged
               rd_vld_nxt  = 1'b1;
               rd_sop_nxt  = g_sop;
               rd_eop_nxt  = g_eop;
               rd_data_nxt = g_data;
               if (g_eop) begin
                  state_nxt   = GAP;
                  por_gnt_nxt = '0;
               end
            end
         end
         GAP: begin
            state_nxt   = IDLE;
            por_gnt_nxt = '0;
         end
         default: begin
            state_nxt   = IDLE;
            por_gnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         last_id     <= ID_W'(PORT_NUM-1);
         gnt_id      <= '0;
         cnt         <= '0;
         por_gnt     <= '0;
         rd_sop      <= 1'b0;
         rd_eop      <= 1'b0;
         rd_vld      <= 1'b0;
         rd_data     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_id     <= last_id_nxt;
         gnt_id      <= gnt_id_nxt;
         cnt         <= cnt_nxt;
         por_gnt     <= por_gnt_nxt;
         rd_sop      <= rd_sop_nxt;
         rd_eop      <= rd_eop_nxt;
         rd_vld      <= rd_vld_nxt;
         rd_data     <= rd_data_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

endmodule
